mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are even integers from 4 to 64.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1: reset reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a multiply, sampled on clk rising edge.
REQ-005 SHALL have port sign, input, 1, 1 = signed two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH, multiplicand; sampled with start.
REQ-007 SHALL have port b, input, WIDTH, multiplier; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress, including the done cycle.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking z as a new valid result.
REQ-010 SHALL have port z, output, 2*WIDTH, product.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE; busy = 1 in CALC and DONE, 0 in IDLE.
REQ-012 SHALL accept start only in IDLE: latch a, b and sign, clear the accumulator, load counter = WIDTH, and go to CALC.
REQ-013 SHALL ignore start, and any change on a, b or sign, while in CALC or DONE; no queuing and no restart.
REQ-014 SHALL, in CALC, process one multiplier bit per cycle by radix-2 shift-add: add the multiplicand (shifted) into a 2*WIDTH accumulator when the current multiplier LSB is 1, shift, and decrement the counter.
REQ-015 SHALL go from CALC to DONE on the cycle the counter reaches 0; CALC lasts exactly WIDTH cycles.
REQ-016 SHALL assert done, and update z, in DONE for exactly one cycle, then return to IDLE.
REQ-017 SHALL assert done exactly WIDTH+1 rising edges after the edge that accepted start; this latency is fixed and independent of operand values.
REQ-018 SHALL hold z at the last result until the next DONE; z SHALL NOT show intermediate accumulator values.
REQ-019 SHALL support back-to-back operation: a start asserted in the cycle after done (IDLE) is accepted.
REQ-020 SHALL, for unsigned mode, produce z = a*b exactly modulo 2^(2*WIDTH); overflow is not possible.
REQ-021 SHALL, for signed mode, take operand magnitudes at acceptance, multiply them unsigned, and negate the product in DONE when sign(a) XOR sign(b) = 1; the most-negative operand SHALL be handled by treating its magnitude as unsigned 2^(WIDTH-1).

Reset
REQ-022 SHALL, on the rising edge where reset = 0, force state = IDLE, busy = 0, done = 0, z = 0, and clear the accumulator, counter and latched operands.
REQ-023 SHALL abort any in-flight operation on reset without asserting done; the first start after reset is released is accepted normally.
REQ-024 SHALL give reset priority over start in the same cycle.

Configuration
REQ-025 SHALL use the macro MULT_SEQ_SIGNED_EN to control signed support.
REQ-026 SHALL, with MULT_SEQ_SIGNED_EN defined, implement signed mode per REQ-021.
REQ-027 SHALL, with MULT_SEQ_SIGNED_EN undefined, ignore the sign input and treat every operation as unsigned; the magnitude and negation logic SHALL be removed. Port list and latency are unchanged.

Verification (WIDTH=32)
REQ-028 SHALL cover: unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> done at edge 33 after start, z=0xFFFFFFFE00000001, busy low the cycle after.
REQ-029 SHALL cover: signed (macro defined) a=0xFFFFFFFD (-3), b=5 -> z=0xFFFFFFFFFFFFFFF1; with the macro undefined, the same stimulus -> z=0x00000004FFFFFFF1.
REQ-030 SHALL cover: signed a=b=0x80000000 -> z=0x4000000000000000; signed a=0x80000000, b=1 -> z=0xFFFFFFFF80000000.
REQ-031 SHALL cover: start pulsed at cycles 5 and 20 of an operation with different operands -> exactly one done, z equals the first operands' product.
REQ-032 SHALL cover: reset=0 at cycle 10 of CALC -> no done, z=0, busy=0; a new start of 7*6 -> z=42 after 33 edges.
REQ-033 SHALL cover: back-to-back starts on every IDLE cycle across 1000 random operand pairs, both sign modes -> every z matches the reference model and each done is spaced exactly 34 cycles apart.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier: WIDTH cycles of CALC, one DONE cycle.
// Define MULT_SEQ_SIGNED_EN to enable signed (magnitude/negate) operation.
module mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_reg, state_next;
   logic [2*WIDTH-1:0] mcand_reg, mcand_next;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [2*WIDTH-1:0] z_reg, z_next;
   logic [WIDTH-1:0]   mplier_reg, mplier_next;
   logic [CW-1:0]      cnt_reg, cnt_next;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] sum;
   logic [2*WIDTH-1:0] result;

   assign sum = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

`ifdef MULT_SEQ_SIGNED_EN
   logic neg_reg;

   // The most-negative value negates to itself, which read as unsigned is 2^(WIDTH-1).
   assign a_mag  = (sign && a[WIDTH-1]) ? -a : a;
   assign b_mag  = (sign && b[WIDTH-1]) ? -b : b;
   assign result = neg_reg ? -sum : sum;

   always_ff @(posedge clk) begin
      if (!reset)
         neg_reg <= 1'b0;
      else if (state_reg == IDLE && start)
         neg_reg <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
   end
`else
   logic unused_sign;

   assign unused_sign = sign;
   assign a_mag       = a;
   assign b_mag       = b;
   assign result      = sum;
`endif

   always_comb begin
      state_next  = state_reg;
      mcand_next  = mcand_reg;
      acc_next    = acc_reg;
      mplier_next = mplier_reg;
      cnt_next    = cnt_reg;
      z_next      = z_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next  = CALC;
               mcand_next  = {{WIDTH{1'b0}}, a_mag};
               acc_next    = '0;
               mplier_next = b_mag;
               cnt_next    = CW'(WIDTH);
            end
         end
         CALC: begin
            acc_next    = sum;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg - CW'(1);
            // Last bit: publish the final product as DONE is entered, so z is valid with done.
            if (cnt_reg == CW'(1)) begin
               state_next = DONE;
               z_next     = result;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         acc_reg    <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
         z_reg      <= '0;
      end else begin
         state_reg  <= state_next;
         mcand_reg  <= mcand_next;
         acc_reg    <= acc_next;
         mplier_reg <= mplier_next;
         cnt_reg    <= cnt_next;
         z_reg      <= z_next;
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign z    = z_reg;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and back-to-back random checks for mult_seq at WIDTH=32.
// Expectations follow MULT_SEQ_SIGNED_EN as the design build does.
module tb_mult_seq;

   localparam int N_RAND = 1000;
`ifdef MULT_SEQ_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sign;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] z;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic        rs [N_RAND];
   logic [31:0] ra [N_RAND];
   logic [31:0] rb [N_RAND];

   mult_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sign  (sign),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      logic [63:0] p;
      p = {32'h0, x} * {32'h0, y};
      if (s && SIGNED_EN) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         p  = 64'(sx * sy);
      end
      return p;
   endfunction

   // Issue one operation from IDLE; edges counts rising edges after acceptance up to the one done is high at.
   task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] zr, output int edges);
      logic d;
      @(negedge clk);
      start = 1'b1; sign = s; a = x; b = y;
      @(posedge clk);
      edges = 0;
      d     = 1'b0;
      zr    = '0;
      while (!d && edges < 60) begin
         @(negedge clk);
         start = 1'b0;
         d  = done;
         zr = z;
         @(posedge clk);
         edges++;
      end
   endtask

   task automatic run_dir(input string tag, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
      logic [63:0] zr;
      int edges;
      do_op(s, x, y, zr, edges);
      #1;
      $display("[TB] %s sign=%0d a=%h b=%h z=%h edges=%0d", tag, s, x, y, zr, edges);
      check({tag, "_z"}, zr, exp);
      check({tag, "_edges"}, 64'(edges), 64'd33);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_done_after"}, 64'(done), 64'd0);
   endtask

   task automatic run_ignore_start();
      int ndone;
      logic [63:0] zr;
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd200;
      @(posedge clk);
      ndone = 0;
      zr    = '0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 5 || c == 20) begin
            start = 1'b1; a = 32'd3 + 32'(c); b = 32'd9;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            zr = z;
         end
      end
      $display("[TB] ignore_start dones=%0d z=%h", ndone, zr);
      check("ignore_start_dones", 64'(ndone), 64'd1);
      check("ignore_start_z", zr, 64'd20000);
   endtask

   task automatic run_abort();
      int ndone;
      logic [63:0] zr;
      int edges;
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'h1234; b = 32'h10;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 5) check("z_hold", z, 64'd20000);
      end
      // Reset and start together: reset must win.
      reset = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_z", z, 64'd0);
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      $display("[TB] abort activity_cycles=%0d", ndone);
      check("abort_no_done", 64'(ndone), 64'd0);
      do_op(1'b0, 32'd7, 32'd6, zr, edges);
      $display("[TB] after_abort 7*6 z=%h edges=%0d", zr, edges);
      check("after_abort_z", zr, 64'd42);
      check("after_abort_edges", 64'(edges), 64'd33);
   endtask

   task automatic run_b2b();
      int t;
      int last_done;
      logic seen;
      for (int i = 0; i < N_RAND; i++) begin
         rs[i] = 1'($urandom_range(0, 1));
         ra[i] = $urandom();
         rb[i] = $urandom();
      end
      ra[1] = 32'h8000_0000; rb[1] = 32'hFFFF_FFFF; rs[1] = 1'b1;
      @(negedge clk);
      start = 1'b1; sign = rs[0]; a = ra[0]; b = rb[0];
      @(posedge clk);
      last_done = -1;
      for (int k = 0; k < N_RAND; k++) begin
         // Operands for the next op sit on the pins while this one runs; they are ignored until IDLE.
         @(negedge clk);
         if (k + 1 < N_RAND) begin
            sign = rs[k+1]; a = ra[k+1]; b = rb[k+1];
         end else begin
            start = 1'b0;
         end
         seen = done;
         t = 1;
         while (!seen && t < 60) begin
            @(negedge clk);
            seen = done;
            t++;
         end
         check("b2b_done_seen", 64'(seen), 64'd1);
         if (!seen) begin
            start = 1'b0;
            return;
         end
         $display("[TB] b2b %0d sign=%0d a=%h b=%h z=%h", k, rs[k], ra[k], rb[k], z);
         check("b2b_z", z, model(rs[k], ra[k], rb[k]));
         if (last_done >= 0) check("b2b_gap", 64'(cyc - last_done), 64'd34);
         last_done = cyc;
         @(posedge clk);
         @(posedge clk);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b1; sign = 1'b0; a = 32'd5; b = 32'd5;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_z", z, 64'd0);
      @(negedge clk);
      reset = 1'b1; start = 1'b0;

      run_dir("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_dir("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5,
              SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);
      run_dir("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_dir("s_minx1", 1'b1, 32'h8000_0000, 32'd1,
              SIGNED_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000);
      run_dir("u_m3x5", 1'b0, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1);
      run_dir("s_7xm1", 1'b1, 32'd7, 32'hFFFF_FFFF,
              SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF9 : 64'h0000_0006_FFFF_FFF9);
      run_dir("u_zero", 1'b0, 32'd0, 32'h1234_5678, 64'd0);

      run_ignore_start();
      run_abort();
      run_b2b();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
